pipe_batch_ctrl: RTL
====================

PIPE_BATCH_CTRL -- requirements
Module: pipe_batch_ctrl

Interface
REQ-001 Parameter IN_WORDS, default 4: number of 32-bit pipe-in words per batch (1..16).
REQ-002 Parameter OUT_WORDS, default 4: number of 32-bit pipe-out words per batch (1..16).
REQ-003 Parameter RES_W, default 16: kernel result width (1..OUT_WORDS*32).
REQ-004 okClk  in  1  clock; all logic on rising edge.
REQ-005 rstn  in  1  reset, synchronous, active-low.
REQ-006 pin_data  in  32  pipe-in word; pin_valid  in  1  write strobe.
REQ-007 start  in  1  one-cycle trigger pulse requesting a kernel run; abort  in  1  one-cycle trigger pulse requesting a return to idle.
REQ-008 k_start  out  1  one-cycle kernel start pulse; k_din  out  IN_WORDS*32  batch operand bus.
REQ-009 k_done  in  1  kernel completion pulse; k_dout  in  RES_W  kernel result, valid while k_done is high.
REQ-010 done_trig  out  1  one-cycle pulse for the trigger-out endpoint.
REQ-011 pout_read  in  1  pipe-out read strobe; pout_data  out  32  pipe-out word.
REQ-012 status  out  32  {24'b0, state[1:0], start_err, ovf, unf, 1'b0, full, busy}.

Function
REQ-013 FSM states: IDLE=0, RUN=1, DRAIN=2; no other state is reachable.
REQ-014 Load: in IDLE, each pin_valid with in_cnt<IN_WORDS writes pin_data to slot IN_WORDS-1-in_cnt of k_din and increments in_cnt; the first word therefore lands in the most significant slot.
REQ-015 pin_valid while in_cnt==IN_WORDS, or while not in IDLE: word dropped, ovf set (sticky).
REQ-016 full = (in_cnt==IN_WORDS); busy = (state==RUN).
REQ-017 start in IDLE with full=1: k_start pulses high the following cycle; state goes to RUN in that same cycle.
REQ-018 start in IDLE with full=0, or start in RUN/DRAIN: ignored, start_err set (sticky), no k_start.
REQ-019 k_din holds stable from k_start until leaving RUN.
REQ-020 RUN with k_done=1: result register <= zero-extended k_dout (OUT_WORDS*32 bits); done_trig pulses high the next cycle; state goes to DRAIN; rd_cnt <= 0; pout_data <= most significant result word.
REQ-021 k_done outside RUN: ignored, no flag.
REQ-022 DRAIN: each pout_read advances rd_cnt; pout_data is updated the next cycle to word rd_cnt+1 (MS-first order). On the read with rd_cnt==OUT_WORDS-1: state goes to IDLE, in_cnt <= 0, pout_data <= 0.
REQ-023 pout_read outside DRAIN: pout_data stays 0, unf set (sticky).
REQ-024 abort in any state: next cycle state=IDLE, in_cnt=0, rd_cnt=0, pout_data=0; k_din and sticky flags are kept; an in-flight kernel result arriving later is ignored per REQ-021.
REQ-025 Simultaneous abort and start: abort wins; start is discarded without setting start_err.
REQ-026 Simultaneous pin_valid and start in IDLE with in_cnt==IN_WORDS-1: the word is stored; start is evaluated against the pre-write count, so full=0 and start_err is set.
REQ-027 Sticky flags ovf, unf and start_err clear only on reset.

Reset
REQ-028 rstn=0 at a clock edge: state=IDLE, in_cnt=0, rd_cnt=0, k_din=0, result=0, pout_data=0, k_start=0, done_trig=0, all flags 0.
REQ-029 Reset mid-RUN or mid-DRAIN: the same values as REQ-028 apply next cycle; a later k_done is ignored.

Verification
REQ-030 Defaults: write 1,2,3,4, pulse start -> k_din=0x00000001_00000002_00000003_00000004, one k_start pulse, busy=1.
REQ-031 Kernel returns k_dout=0xBEEF -> done_trig pulses once; 4 reads return 0,0,0,0x0000BEEF; state returns to IDLE.
REQ-032 Write 5 words -> fifth word dropped, ovf=1, full=1; start still runs using words 1..4.
REQ-033 Start after 3 words -> no k_start, start_err=1, state stays IDLE.
REQ-034 Abort during RUN, then k_done -> state IDLE, no done_trig, pout_read gives 0 and sets unf=1.
REQ-035 IN_WORDS=8, OUT_WORDS=2, RES_W=48: 8-word load, run, result 0x123456789ABC -> reads return 0x00001234, then 0x56789ABC.

Source files
------------

// File: rtl/pipe_batch_ctrl.sv
// pipe_batch_ctrl: batches pipe-in words into a kernel operand, runs the kernel, drains its result to pipe-out
module pipe_batch_ctrl #(
   parameter int IN_WORDS  = 4,
   parameter int OUT_WORDS = 4,
   parameter int RES_W     = 16
) (
   input  logic                     okClk,
   input  logic                     rstn,
   input  logic [31:0]              i_pin_data,
   input  logic                     i_pin_valid,
   input  logic                     i_start,
   input  logic                     i_abort,
   output logic                     o_k_start,
   output logic [IN_WORDS*32-1:0]   o_k_din,
   input  logic                     i_k_done,
   input  logic [RES_W-1:0]         i_k_dout,
   output logic                     o_done_trig,
   input  logic                     i_pout_read,
   output logic [31:0]              o_pout_data,
   output logic [31:0]              o_status
);
   localparam logic [1:0] S_IDLE  = 2'd0;
   localparam logic [1:0] S_RUN   = 2'd1;
   localparam logic [1:0] S_DRAIN = 2'd2;
   localparam int RW = OUT_WORDS*32;
   logic [1:0]             r_state, w_next;
   logic [4:0]             r_in_cnt;
   logic [3:0]             r_rd_cnt;
   logic [IN_WORDS*32-1:0] r_kdin;
   logic [RW-1:0]          r_result, w_kres;
   logic [31:0]            r_pout, w_nword;
   logic                   r_kstart, r_done_trig, r_ovf, r_unf, r_serr;
   logic                   w_idle, w_run, w_drain, w_full, w_load, w_start_ok, w_fin, w_last_rd;
   assign w_idle     = r_state == S_IDLE;
   assign w_run      = r_state == S_RUN;
   assign w_drain    = r_state == S_DRAIN;
   assign w_full     = r_in_cnt == 5'(IN_WORDS);
   assign w_load     = w_idle & i_pin_valid & ~w_full & ~i_abort;
   assign w_start_ok = w_idle & i_start & w_full & ~i_abort;
   assign w_fin      = w_run & i_k_done & ~i_abort;
   assign w_last_rd  = w_drain & i_pout_read & (r_rd_cnt == 4'(OUT_WORDS-1));
   assign w_nword    = 32'((r_result << {r_rd_cnt + 4'd1, 5'd0}) >> (RW-32));
   // zero-extend the kernel result to the full pipe-out width
   always_comb begin
      w_kres = '0;
      w_kres[RES_W-1:0] = i_k_dout;
   end
   // state register
   always_ff @(posedge okClk)
      if (!rstn) r_state <= S_IDLE;
      else r_state <= w_next;
   // next state: abort dominates every transition
   always_comb
      w_next = i_abort ? S_IDLE : w_start_ok ? S_RUN : w_fin ? S_DRAIN : w_last_rd ? S_IDLE : r_state;
   // outputs are registered values plus the status word
   always_comb begin
      o_k_start   = r_kstart;
      o_k_din     = r_kdin;
      o_done_trig = r_done_trig;
      o_pout_data = r_pout;
      o_status    = {24'b0, r_state, r_serr, r_ovf, r_unf, 1'b0, w_full, w_run};
   end
   // one-cycle pulses and sticky error flags
   always_ff @(posedge okClk)
      if (!rstn) begin
         r_kstart    <= 1'b0;
         r_done_trig <= 1'b0;
         r_ovf       <= 1'b0;
         r_unf       <= 1'b0;
         r_serr      <= 1'b0;
      end else begin
         r_kstart    <= w_start_ok;
         r_done_trig <= w_fin;
         if (i_pin_valid && !(w_idle && !w_full)) r_ovf <= 1'b1;
         if (i_pout_read && !w_drain) r_unf <= 1'b1;
         if (i_start && !i_abort && !w_start_ok) r_serr <= 1'b1;
      end
   // operand loading: first word lands in the most significant slot
   always_ff @(posedge okClk)
      if (!rstn) begin
         r_kdin   <= '0;
         r_in_cnt <= '0;
      end else begin
         for (int j = 0; j < IN_WORDS; j++)
            if (w_load && r_in_cnt == 5'(IN_WORDS-1-j)) r_kdin[j*32 +: 32] <= i_pin_data;
         if (i_abort || w_last_rd) r_in_cnt <= '0;
         else if (w_load) r_in_cnt <= r_in_cnt + 5'd1;
      end
   // result capture and MS-first drain to pipe-out
   always_ff @(posedge okClk)
      if (!rstn) begin
         r_result <= '0;
         r_rd_cnt <= '0;
         r_pout   <= '0;
      end else begin
         if (w_fin) r_result <= w_kres;
         if (i_abort) begin
            r_rd_cnt <= '0;
            r_pout   <= '0;
         end else if (w_fin) begin
            r_rd_cnt <= '0;
            r_pout   <= 32'(w_kres >> (RW-32));
         end else if (w_drain && i_pout_read) begin
            r_rd_cnt <= r_rd_cnt + 4'd1;
            r_pout   <= w_last_rd ? 32'd0 : w_nword;
         end
      end
endmodule
